// File: rtl/intersection_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_scheduler
//   Demand-actuated two-road traffic-light controller. Road A and road B light
//   heads (x=green, v=yellow, d=red) cycle through green / yellow / all-red
//   phases. Green is extended while the cross road has no pending demand. An
//   emergency 'stop' forces an all-red HOLD, and a phase countdown is exported
//   for the board display.
//
// Parameters
//   TW        width of phase timer and cnt output
//   GREEN_T   green phase length in ck cycles (1..2^TW)
//   YELLOW_T  yellow phase length in ck cycles (1..2^TW)
//   ALLRED_T  all-red clearance length in ck cycles (1..2^TW)
//
// Ports
//   ck        clock, all logic on posedge
//   rs        synchronous active-low reset
//   stop      emergency hold, level, active-high
//   req_a/b   road A / road B vehicle demand (pulse or level)
//   xa,va,da  road A green / yellow / red
//   xb,vb,db  road B green / yellow / red
//   cnt       cycles remaining in current phase minus 1
//   st        state code (also the FSM debug view)
//   HEX       (only with SEG7_EN) active-low 7-segment decode of cnt[3:0],
//             bit 7 = decimal point, lit (0) during yellow
//
// Optional build macro: SEG7_EN adds the HEX output and its decoder.
// -----------------------------------------------------------------------------
module intersection_scheduler #(
  parameter int TW       = 5,
  parameter int GREEN_T  = 6,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1
) (
  input  logic          ck,
  input  logic          rs,
  input  logic          stop,
  input  logic          req_a,
  input  logic          req_b,
  output logic          xa,
  output logic          va,
  output logic          da,
  output logic          xb,
  output logic          vb,
  output logic          db,
  output logic [TW-1:0] cnt,
  output logic [2:0]    st
`ifdef SEG7_EN
  ,
  output logic [7:0]    HEX
`endif
);

  localparam logic [2:0] S_ARA  = 3'd0;
  localparam logic [2:0] S_AG   = 3'd1;
  localparam logic [2:0] S_AY   = 3'd2;
  localparam logic [2:0] S_ARB  = 3'd3;
  localparam logic [2:0] S_BG   = 3'd4;
  localparam logic [2:0] S_BY   = 3'd5;
  localparam logic [2:0] S_HOLD = 3'd6;

  // Reload values are T-1 taken modulo 2^TW, so T=2^TW loads all-ones.
  localparam logic [TW-1:0] G_LD = TW'(GREEN_T - 1);
  localparam logic [TW-1:0] Y_LD = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] R_LD = TW'(ALLRED_T - 1);

  logic          pend_a;
  logic          pend_b;
  logic          last_a;   // 1: road A was the most recent road to enter green
  logic [2:0]    st_nx;
  logic [TW-1:0] cnt_nx;
  logic          tdone;

  assign tdone = (cnt == '0);

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt - TW'(1);
    if (stop) begin
      st_nx  = S_HOLD;
      cnt_nx = '0;
    end else begin
      case (st)
        S_ARA: if (tdone) begin st_nx = S_AG;  cnt_nx = G_LD; end
        S_AG: begin
          if (tdone) begin
            // Stay green (reload) until road B has demand waiting.
            if (pend_b) begin st_nx = S_AY; cnt_nx = Y_LD; end
            else        cnt_nx = G_LD;
          end
        end
        S_AY:  if (tdone) begin st_nx = S_ARB; cnt_nx = R_LD; end
        S_ARB: if (tdone) begin st_nx = S_BG;  cnt_nx = G_LD; end
        S_BG: begin
          if (tdone) begin
            if (pend_a) begin st_nx = S_BY; cnt_nx = Y_LD; end
            else        cnt_nx = G_LD;
          end
        end
        S_BY:  if (tdone) begin st_nx = S_ARA; cnt_nx = R_LD; end
        S_HOLD: begin
          // Resume by clearing toward the road that did not have green last.
          st_nx  = last_a ? S_ARB : S_ARA;
          cnt_nx = R_LD;
        end
        default: begin
          st_nx  = S_ARA;
          cnt_nx = R_LD;
        end
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (!rs) begin
      st     <= S_ARA;
      cnt    <= R_LD;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      last_a <= 1'b0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      // Entering green consumes the demand; that clear beats a same-edge request.
      if (st_nx == S_AG)                pend_a <= 1'b0;
      else if (req_a && (st != S_AG))   pend_a <= 1'b1;
      if (st_nx == S_BG)                pend_b <= 1'b0;
      else if (req_b && (st != S_BG))   pend_b <= 1'b1;
      if (st_nx == S_AG)      last_a <= 1'b1;
      else if (st_nx == S_BG) last_a <= 1'b0;
    end
  end

  // Moore light decode; every non-green/yellow code (including illegal) is all-red.
  always_comb begin
    {xa, va, da} = 3'b001;
    {xb, vb, db} = 3'b001;
    case (st)
      S_AG: {xa, va, da} = 3'b100;
      S_AY: {xa, va, da} = 3'b010;
      S_BG: {xb, vb, db} = 3'b100;
      S_BY: {xb, vb, db} = 3'b010;
      default: ;
    endcase
  end

`ifdef SEG7_EN
  logic [6:0] seg;

  always_comb begin
    seg = 7'h7F;
    case (cnt[3:0])
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

  // Display is blanked in HOLD and while reset is asserted.
  assign HEX = (!rs || (st == S_HOLD)) ? 8'hFF
             : {~((st == S_AY) || (st == S_BY)), seg};
`endif

endmodule

// File: tb/tb_intersection_scheduler.sv
// -----------------------------------------------------------------------------
// tb_intersection_scheduler
//   Directed bench for intersection_scheduler at default parameters
//   (TW=5, GREEN_T=6, YELLOW_T=2, ALLRED_T=1). A vector table of
//   {inputs, expected st/cnt} records is applied one clock edge per record;
//   expected lights are derived from the expected state code. A second
//   sequence holds both requests and checks the steady phase cycle and the
//   green/yellow exclusion between roads.
// -----------------------------------------------------------------------------
module tb_intersection_scheduler;

  typedef struct {
    logic       rs;
    logic       stop;
    logic       ra;
    logic       rb;
    logic [2:0] est;
    logic [4:0] ecnt;
  } vec_t;

  // clock / reset
  logic       ck = 1'b0;
  logic       rs = 1'b0;
  logic       stop = 1'b0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       xa, va, da, xb, vb, db;
  logic [4:0] cnt;
  logic [2:0] st;
`ifdef SEG7_EN
  logic [7:0] hex;
`endif

  always #5 ck = ~ck;

  intersection_scheduler dut (
    .ck(ck), .rs(rs), .stop(stop), .req_a(req_a), .req_b(req_b),
    .xa(xa), .va(va), .da(da), .xb(xb), .vb(vb), .db(db),
    .cnt(cnt), .st(st)
`ifdef SEG7_EN
    , .HEX(hex)
`endif
  );

  // scoreboard state
  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;

  function automatic logic [5:0] lights_of(input logic [2:0] s);
    case (s)
      3'd1:    return 6'b100_001;
      3'd2:    return 6'b010_001;
      3'd4:    return 6'b001_100;
      3'd5:    return 6'b001_010;
      default: return 6'b001_001;
    endcase
  endfunction

  // driver tasks
  task automatic add(input logic r, input logic s, input logic a, input logic b,
                     input int est, input int ecnt);
    vec_t v;
    v.rs = r; v.stop = s; v.ra = a; v.rb = b;
    v.est = 3'(est); v.ecnt = 5'(ecnt);
    vecs.push_back(v);
  endtask

  task automatic drive_edge(input logic r, input logic s, input logic a, input logic b);
    rs = r; stop = s; req_a = a; req_b = b;
    @(posedge ck);
    #1;
  endtask

  task automatic check_state(input string name, input int idx,
                             input logic [2:0] est, input logic [4:0] ecnt);
    logic [5:0] el;
    logic [5:0] al;
    el = lights_of(est);
    al = {xa, va, da, xb, vb, db};
    checks++;
    if (st !== est || cnt !== ecnt || al !== el) begin
      failures++;
      $display("FAIL %s[%0d]: got st=%0d cnt=%0d lights=%b, want st=%0d cnt=%0d lights=%b",
               name, idx, st, cnt, al, est, ecnt, el);
    end
  endtask

  initial begin
    // reset, then free-running A green with extension
    add(0,0,0,0, 0,0);
    add(0,0,0,0, 0,0);
    add(1,0,0,0, 1,5);
    for (int k = 4; k >= 0; k--) add(1,0,0,0, 1,k);
    add(1,0,0,0, 1,5);
    add(1,0,0,0, 1,4);
    add(1,0,0,0, 1,3);
    // req_b pulse at cnt=3: green runs out, then yellow, all-red, B green
    add(1,0,0,1, 1,2);
    add(1,0,0,0, 1,1);
    add(1,0,0,0, 1,0);
    add(1,0,0,0, 2,1);
    add(1,0,0,0, 2,0);
    add(1,0,0,0, 3,0);
    add(1,0,0,0, 4,5);
    // B green extends with no A demand
    for (int k = 4; k >= 0; k--) add(1,0,0,0, 4,k);
    add(1,0,0,0, 4,5);
    // req_a ends B green; stop during B_Y, release resumes at AR_A
    add(1,0,1,0, 4,4);
    for (int k = 3; k >= 0; k--) add(1,0,0,0, 4,k);
    add(1,0,0,0, 5,1);
    for (int k = 0; k < 4; k++) add(1,1,0,0, 6,0);
    add(1,0,0,0, 0,0);
    add(1,0,0,0, 1,5);
    // stop during A green, release resumes at AR_B
    add(1,1,0,0, 6,0);
    add(1,0,0,0, 3,0);
    add(1,0,0,0, 4,5);
    // reset mid B green with pend_a set
    add(1,0,1,0, 4,4);
    add(1,0,0,0, 4,3);
    add(1,0,0,0, 4,2);
    add(0,0,0,0, 0,0);
    add(1,0,0,0, 1,5);
    for (int k = 4; k >= 0; k--) add(1,0,0,0, 1,k);
    add(1,0,0,0, 1,5);
    // reset clears a pending B demand: A green keeps extending
    add(1,0,0,1, 1,4);
    add(0,0,0,0, 0,0);
    add(1,0,0,0, 1,5);
    for (int k = 4; k >= 0; k--) add(1,0,0,0, 1,k);
    add(1,0,0,0, 1,5);
    // reset beats stop; req_a on the edge entering A_G is discarded,
    // so B green later extends instead of yielding
    add(0,1,0,0, 0,0);
    add(1,0,1,0, 1,5);
    add(1,0,0,1, 1,4);
    for (int k = 3; k >= 0; k--) add(1,0,0,0, 1,k);
    add(1,0,0,0, 2,1);
    add(1,0,0,0, 2,0);
    add(1,0,0,0, 3,0);
    add(1,0,0,0, 4,5);
    for (int k = 4; k >= 0; k--) add(1,0,0,0, 4,k);
    add(1,0,0,0, 4,5);

    #2;
    foreach (vecs[i]) begin
      drive_edge(vecs[i].rs, vecs[i].stop, vecs[i].ra, vecs[i].rb);
      check_state("vec", i, vecs[i].est, vecs[i].ecnt);
    end

    // both requests held: steady 1/6/2/1/6/2 cycle
    begin
      int dur[6];
      int code[6];
      logic [7:0] e;
      dur  = '{6, 2, 1, 6, 2, 1};
      code = '{1, 2, 3, 4, 5, 0};
      exp_q.push_back({3'd0, 5'd0});
      for (int r = 0; r < 2; r++)
        for (int p = 0; p < 6; p++)
          for (int k = 0; k < dur[p]; k++)
            exp_q.push_back({3'(code[p]), 5'(dur[p] - 1 - k)});
      drive_edge(0, 0, 1, 1);
      e = exp_q.pop_front();
      check_state("held_rst", 0, e[7:5], e[4:0]);
      for (int n = 1; exp_q.size() > 0; n++) begin
        drive_edge(1, 0, 1, 1);
        e = exp_q.pop_front();
        check_state("held", n, e[7:5], e[4:0]);
        checks++;
        if ((xa | va) && (xb | vb)) begin
          failures++;
          $display("FAIL excl[%0d]: got a=%b%b b=%b%b, want no road-A and road-B go/yellow together",
                   n, xa, va, xb, vb);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
